// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: circular FIFO of {instruction, pc} pairs between
// fetch and decode/dispatch. Pops land in a registered output pair; flush
// discards everything on a redirect.
module instr_fetch_queue #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic        flush,
  input  logic [31:0] instruction_in,
  input  logic [31:0] pc_in,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  output logic        empty,
  output logic        full
);

  localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

  logic [31:0] mem_instr [DEPTH];
  logic [31:0] mem_pc    [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       instr_out_q, instr_out_d;
  logic [31:0]       pc_out_q, pc_out_d;

  logic push_ok;
  logic pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == FullCount);

  // Acceptance uses pre-edge occupancy, so a full queue still pops but
  // rejects a same-cycle push, and an empty queue never bypasses.
  assign push_ok = wr_en & ~full;
  assign pop_ok  = rd_en & ~empty;

  assign instruction_out = instr_out_q;
  assign pc_out          = pc_out_q;

  // Next-state for pointers, occupancy and the registered output pair.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    instr_out_d = instr_out_q;
    pc_out_d    = pc_out_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      instr_out_d = '0;
      pc_out_d    = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
        instr_out_d = mem_instr[rd_ptr_q];
        pc_out_d    = mem_pc[rd_ptr_q];
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
        2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      instr_out_q <= '0;
      pc_out_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      instr_out_q <= instr_out_d;
      pc_out_q    <= pc_out_d;
    end
  end

  // Storage write; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem_instr[wr_ptr_q] <= instruction_in;
      mem_pc[wr_ptr_q]    <= pc_in;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: accepted pushes go into a model
// queue, accepted pops take the front entry as the expected output pair.
module tb_instr_fetch_queue;

  localparam int unsigned Depth = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic        flush;
  logic [31:0] instruction_in;
  logic [31:0] pc_in;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic        empty;
  logic        full;

  instr_fetch_queue #(.DEPTH(Depth)) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_en           (wr_en),
    .rd_en           (rd_en),
    .flush           (flush),
    .instruction_in  (instruction_in),
    .pc_in           (pc_in),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .empty           (empty),
    .full            (full)
  );

  always #5 clk = ~clk;

  logic [63:0] sb_q [$];
  logic [31:0] exp_instr;
  logic [31:0] exp_pc;
  int          n_checks;
  int          n_pass;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".instr"}, instruction_out, exp_instr);
    check_eq({tag, ".pc"}, pc_out, exp_pc);
    check_eq({tag, ".empty"}, 32'(empty), 32'(sb_q.size() == 0));
    check_eq({tag, ".full"}, 32'(full), 32'(sb_q.size() == Depth));
  endtask

  // One clock: drive inputs, update the model at the edge, check just after.
  task automatic cycle(input string tag, input logic w, input logic r, input logic f,
                       input logic [31:0] pc);
    logic        push_ok;
    logic        pop_ok;
    logic [31:0] instr;
    logic [63:0] ent;
    instr          = $urandom;
    wr_en          = w;
    rd_en          = r;
    flush          = f;
    instruction_in = instr;
    pc_in          = pc;
    push_ok = w && (sb_q.size() < Depth);
    pop_ok  = r && (sb_q.size() > 0);
    @(posedge clk);
    if (f) begin
      sb_q.delete();
      exp_instr = '0;
      exp_pc    = '0;
    end else begin
      if (pop_ok) begin
        ent       = sb_q.pop_front();
        exp_instr = ent[63:32];
        exp_pc    = ent[31:0];
      end
      if (push_ok) sb_q.push_back({instr, pc});
    end
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
    check_all(tag);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    exp_instr = '0;
    exp_pc    = '0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
    instruction_in = '0;
    pc_in = '0;

    // Reset
    rst = 1'b1;
    #10;
    rst = 1'b0;
    #2;
    check_all("reset");

    // Single push/pop with the plan's fixed word
    wr_en = 1'b1; rd_en = 1'b0; flush = 1'b0;
    instruction_in = 32'h0050_0093; pc_in = 32'h0;
    @(posedge clk);
    sb_q.push_back({32'h0050_0093, 32'h0});
    #1;
    wr_en = 1'b0;
    check_all("single_push");
    cycle("single_pop", 1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("single_pop.word", instruction_out, 32'h0050_0093);

    // Flush overrides a same-cycle push
    cycle("flush_pre", 1'b1, 1'b0, 1'b0, 32'h4);
    cycle("flush", 1'b1, 1'b0, 1'b1, 32'h8);
    cycle("flush_pop", 1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("flush_pop.pc0", pc_out, 32'h0);

    // Fill, overflow, drain, pop on empty
    for (int i = 0; i < 8; i++) cycle("fill", 1'b1, 1'b0, 1'b0, 32'(i * 4));
    check_eq("fill.full", 32'(full), 32'd1);
    cycle("overflow", 1'b1, 1'b0, 1'b0, 32'h20);
    for (int i = 0; i < 8; i++) begin
      cycle("drain", 1'b0, 1'b1, 1'b0, 32'h0);
      check_eq("drain.order", pc_out, 32'(i * 4));
    end
    cycle("empty_pop", 1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("empty_pop.hold", pc_out, 32'h1C);

    // Wrap-around with simultaneous push/pop
    for (int i = 0; i < 5; i++) cycle("wrap_push", 1'b1, 1'b0, 1'b0, 32'h100 + 32'(i * 4));
    for (int i = 0; i < 5; i++) cycle("wrap_pop", 1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) cycle("wrap_push3", 1'b1, 1'b0, 1'b0, 32'h200 + 32'(i * 4));
    for (int i = 0; i < 10; i++) cycle("wrap_both", 1'b1, 1'b1, 1'b0, 32'h300 + 32'(i * 4));
    check_eq("wrap_both.count", 32'(sb_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) cycle("wrap_drain", 1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("wrap_drain.last", pc_out, 32'h324);

    // Full with simultaneous push/pop: pop only
    for (int i = 0; i < 8; i++) cycle("full2_fill", 1'b1, 1'b0, 1'b0, 32'h400 + 32'(i * 4));
    cycle("full2_both", 1'b1, 1'b1, 1'b0, 32'h500);
    check_eq("full2_both.head", pc_out, 32'h400);
    for (int i = 0; i < 7; i++) cycle("full2_drain", 1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("full2_drain.last", pc_out, 32'h41C);

    // Async reset between edges
    for (int i = 0; i < 4; i++) cycle("arst_fill", 1'b1, 1'b0, 1'b0, 32'h600 + 32'(i * 4));
    cycle("arst_pop", 1'b0, 1'b1, 1'b0, 32'h0);
    #2;
    rst = 1'b1;
    sb_q.delete();
    exp_instr = '0;
    exp_pc    = '0;
    #1;
    check_all("arst");
    #1;
    rst = 1'b0;
    cycle("arst_after", 1'b0, 1'b1, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
